// File: rtl/multi_cycle_controller.sv
`default_nettype none
// ============================================================================
// Module      : multi_cycle_controller
// Description : Control FSM for a multi-cycle MIPS-style datapath. Sequences
//               fetch/decode/execute/memory/writeback, aborts memory waits
//               after MEM_TIMEOUT cycles and flags unsupported opcodes.
//               Optional feature macro: ADDI_SUPPORT_EN (addi via states
//               ADDIEX/ADDIWB; when undefined, addi is an illegal opcode).
// Revision    : 1.0 - initial release
// ============================================================================
module multi_cycle_controller #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       Branch,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUop,
  output logic [1:0] PCSource,
  output logic [3:0] state,
  output logic       instr_done,
  output logic       illegal_op,
  output logic       mem_err
);

`ifdef ADDI_SUPPORT_EN
  localparam bit ADDI_EN = 1'b1;
`else
  localparam bit ADDI_EN = 1'b0;
`endif

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  // Counter only has to hold 0..MEM_TIMEOUT-1; the abort fires on the
  // cycle that would have taken it to MEM_TIMEOUT.
  localparam int              CNT_W    = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  state_t           cur_state;
  state_t           next_state;
  logic [CNT_W-1:0] wait_cnt;
  logic             waiting;
  logic             timeout;
  logic             op_legal;
  logic             decode_illegal;

  assign state = cur_state;

  // Next-state selection, memory-wait detection and opcode legality.
  always_comb begin
    waiting        = 1'b0;
    timeout        = 1'b0;
    op_legal       = 1'b0;
    decode_illegal = 1'b0;
    next_state     = S_FETCH;

    case (opcode)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J: op_legal = 1'b1;
      OP_ADDI:                             op_legal = ADDI_EN;
      default:                             op_legal = 1'b0;
    endcase

    if ((cur_state == S_FETCH || cur_state == S_MEMRD || cur_state == S_MEMWR) && !mem_ready)
      waiting = 1'b1;
    timeout = waiting && (wait_cnt >= CNT_LAST);

    case (cur_state)
      S_FETCH:  next_state = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: next_state = S_MEMADR;
          OP_RTYPE:     next_state = S_EXEC;
          OP_BEQ:       next_state = S_BRANCH;
          OP_J:         next_state = S_JUMP;
          OP_ADDI:      next_state = ADDI_EN ? S_ADDIEX : S_FETCH;
          default:      next_state = S_FETCH;
        endcase
        decode_illegal = !op_legal;
      end
      S_MEMADR: next_state = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  next_state = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWB:  next_state = S_FETCH;
      S_MEMWR:  next_state = mem_ready ? S_FETCH : S_MEMWR;
      S_EXEC:   next_state = S_ALUWB;
      S_ALUWB:  next_state = S_FETCH;
      S_BRANCH: next_state = S_FETCH;
      S_JUMP:   next_state = S_FETCH;
      S_ADDIEX: next_state = ADDI_EN ? S_ADDIWB : S_FETCH;
      S_ADDIWB: next_state = S_FETCH;
      default:  next_state = S_FETCH;
    endcase

    if (timeout)
      next_state = S_FETCH;
  end

  // State register, wait counter and the one-cycle error flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      cur_state  <= S_FETCH;
      wait_cnt   <= '0;
      illegal_op <= 1'b0;
      mem_err    <= 1'b0;
    end else begin
      cur_state  <= next_state;
      // Staying in a wait state keeps counting; any exit, ready or abort clears.
      wait_cnt   <= (waiting && !timeout) ? wait_cnt + 1'b1 : '0;
      illegal_op <= decode_illegal;
      mem_err    <= timeout;
    end
  end

  // Datapath controls decoded from the current state; strobes held off in reset.
  always_comb begin
    PCWrite    = 1'b0;
    Branch     = 1'b0;
    IorD       = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    MemtoReg   = 1'b0;
    RegDst     = 1'b0;
    RegWrite   = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ALUop      = 2'b00;
    PCSource   = 2'b00;
    instr_done = 1'b0;

    case (cur_state)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
      end
      S_DECODE: ALUSrcB = 2'b11;
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_MEMRD: begin
        IorD    = 1'b1;
        MemRead = 1'b1;
      end
      S_MEMWB: begin
        MemtoReg   = 1'b1;
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_MEMWR: begin
        IorD       = 1'b1;
        MemWrite   = 1'b1;
        instr_done = mem_ready;
      end
      S_EXEC: begin
        ALUSrcA = 1'b1;
        ALUop   = 2'b10;
      end
      S_ALUWB: begin
        RegDst     = 1'b1;
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA    = 1'b1;
        ALUop      = 2'b01;
        PCSource   = 2'b01;
        Branch     = 1'b1;
        instr_done = 1'b1;
      end
      S_JUMP: begin
        PCSource   = 2'b10;
        PCWrite    = 1'b1;
        instr_done = 1'b1;
      end
      S_ADDIEX: begin
        ALUSrcA = ADDI_EN;
        ALUSrcB = ADDI_EN ? 2'b10 : 2'b00;
      end
      S_ADDIWB: begin
        RegWrite   = ADDI_EN;
        instr_done = ADDI_EN;
      end
      default: ;
    endcase

    // An instruction interrupted by reset must not commit anything.
    if (reset) begin
      PCWrite    = 1'b0;
      IRWrite    = 1'b0;
      MemWrite   = 1'b0;
      RegWrite   = 1'b0;
      instr_done = 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_multi_cycle_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_multi_cycle_controller
// Description : Self-checking bench for multi_cycle_controller. A per-
//               instruction path model (queue of states still to visit)
//               predicts state, controls and flags every cycle.
//               Honours ADDI_SUPPORT_EN the same way as the design.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multi_cycle_controller;

  localparam int TO = 4;
`ifdef ADDI_SUPPORT_EN
  localparam bit ADDI_EN = 1'b1;
`else
  localparam bit ADDI_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] opcode = 6'd0;
  logic       mem_ready = 1'b0;
  logic       PCWrite, Branch, IorD, MemRead, MemWrite, IRWrite;
  logic       MemtoReg, RegDst, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB, ALUop, PCSource;
  logic [3:0] state;
  logic       instr_done, illegal_op, mem_err;

  multi_cycle_controller #(.MEM_TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .Branch(Branch), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg),
    .RegDst(RegDst), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUop(ALUop), .PCSource(PCSource), .state(state),
    .instr_done(instr_done), .illegal_op(illegal_op), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  logic [16:0] dut_ctrl;
  assign dut_ctrl = {PCWrite, Branch, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
                     RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUop, PCSource, instr_done};

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: current state, states still to visit, wait length, flags.
  logic [3:0]  exp_state   = 4'd0;
  logic [3:0]  m_path[$];
  int          m_wait      = 0;
  logic        exp_illegal = 1'b0;
  logic        exp_memerr  = 1'b0;
  logic [16:0] exp_ctrl    = '0;

  // Control word each state should present (table of the datapath meanings).
  function automatic logic [16:0] ctrl_of(input logic [3:0] s, input logic mr, input logic rst);
    logic pcw, br, iord, mrd, mwr, irw, m2r, rdst, rw, asa, done;
    logic [1:0] asb, aop, pcs;
    {pcw, br, iord, mrd, mwr, irw, m2r, rdst, rw, asa, done} = '0;
    {asb, aop, pcs} = '0;
    case (s)
      4'd0:  begin mrd = 1; asb = 2'b01; irw = mr; pcw = mr; end
      4'd1:  asb = 2'b11;
      4'd2:  begin asa = 1; asb = 2'b10; end
      4'd3:  begin iord = 1; mrd = 1; end
      4'd4:  begin m2r = 1; rw = 1; done = 1; end
      4'd5:  begin iord = 1; mwr = 1; done = mr; end
      4'd6:  begin asa = 1; aop = 2'b10; end
      4'd7:  begin rdst = 1; rw = 1; done = 1; end
      4'd8:  begin asa = 1; aop = 2'b01; pcs = 2'b01; br = 1; done = 1; end
      4'd9:  begin pcs = 2'b10; pcw = 1; done = 1; end
      4'd10: if (ADDI_EN) begin asa = 1; asb = 2'b10; end
      4'd11: if (ADDI_EN) begin rw = 1; done = 1; end
      default: ;
    endcase
    if (rst) {pcw, mwr, irw, rw, done} = '0;
    return {pcw, br, iord, mrd, mwr, irw, m2r, rdst, rw, asa, asb, aop, pcs, done};
  endfunction

  // States an instruction visits after DECODE; empty means unsupported.
  task automatic set_route(input logic [5:0] op);
    m_path.delete();
    case (op)
      6'b100011: begin m_path.push_back(4'd2); m_path.push_back(4'd3); m_path.push_back(4'd4); end
      6'b101011: begin m_path.push_back(4'd2); m_path.push_back(4'd5); end
      6'b000000: begin m_path.push_back(4'd6); m_path.push_back(4'd7); end
      6'b000100: m_path.push_back(4'd8);
      6'b000010: m_path.push_back(4'd9);
      6'b001000: if (ADDI_EN) begin m_path.push_back(4'd10); m_path.push_back(4'd11); end
      default: ;
    endcase
  endtask

  // Advance the model across one rising edge using the inputs seen there.
  task automatic model_edge(input logic mr, input logic [5:0] op, input logic rst);
    if (rst) begin
      exp_state = 4'd0; m_path.delete(); m_wait = 0;
      exp_illegal = 0; exp_memerr = 0;
      return;
    end
    exp_illegal = 0;
    exp_memerr  = 0;
    if ((exp_state == 4'd0 || exp_state == 4'd3 || exp_state == 4'd5) && !mr) begin
      m_wait++;
      if (m_wait >= TO) begin
        m_wait = 0; m_path.delete(); exp_state = 4'd0; exp_memerr = 1;
      end
      return;
    end
    m_wait = 0;
    if (exp_state == 4'd0) begin
      exp_state = 4'd1;
    end else begin
      if (exp_state == 4'd1) begin
        set_route(op);
        if (m_path.size() == 0) exp_illegal = 1;
      end
      exp_state = (m_path.size() != 0) ? m_path.pop_front() : 4'd0;
    end
  endtask

  task automatic drive(input logic mr, input logic [5:0] op, input logic rst);
    @(negedge clk);
    mem_ready = mr; opcode = op; reset = rst;
    #1;
    exp_ctrl = ctrl_of(exp_state, mr, rst);
  endtask

  task automatic advance();
    @(posedge clk);
    model_edge(mem_ready, opcode, reset);
  endtask

  task automatic test_reset();
    drive(1'b1, 6'd0, 1'b1);
    advance();
    drive(1'($urandom_range(0, 1)), 6'd0, 1'b1);
    n_checks += 4;
    if (state !== 4'd0) begin n_fail++; $display("FAIL reset state: got %0d want 0", state); end
    if (dut_ctrl !== exp_ctrl) begin n_fail++; $display("FAIL reset ctrl: got %b want %b", dut_ctrl, exp_ctrl); end
    if (illegal_op !== 1'b0) begin n_fail++; $display("FAIL reset illegal_op: got %b want 0", illegal_op); end
    if (mem_err !== 1'b0) begin n_fail++; $display("FAIL reset mem_err: got %b want 0", mem_err); end
    advance();
  endtask

  task automatic test_rtype();
    int seq[5] = '{0, 1, 6, 7, 0};
    int dones = 0;
    for (int i = 0; i < 5; i++) begin
      drive((i < 4) ? 1'b1 : 1'b0, 6'b000000, 1'b0);
      n_checks += 5;
      if (state !== seq[i][3:0]) begin n_fail++; $display("FAIL rtype state[%0d]: got %0d want %0d", i, state, seq[i]); end
      if (dut_ctrl !== exp_ctrl) begin n_fail++; $display("FAIL rtype ctrl[%0d]: got %b want %b", i, dut_ctrl, exp_ctrl); end
      if (illegal_op !== exp_illegal) begin n_fail++; $display("FAIL rtype illegal_op: got %b want %b", illegal_op, exp_illegal); end
      if (mem_err !== exp_memerr) begin n_fail++; $display("FAIL rtype mem_err: got %b want %b", mem_err, exp_memerr); end
      if (state !== exp_state) begin n_fail++; $display("FAIL rtype model state: got %0d want %0d", state, exp_state); end
      if (instr_done === 1'b1) dones++;
      advance();
    end
    n_checks++;
    if (dones != 1) begin n_fail++; $display("FAIL rtype instr_done pulses: got %0d want 1", dones); end
  endtask

  task automatic test_load();
    int         seq[9] = '{0, 1, 2, 3, 3, 3, 3, 4, 0};
    logic [8:0] mr     = 9'b011000111;   // bit i = mem_ready in cycle i
    for (int i = 0; i < 9; i++) begin
      drive(mr[i], 6'b100011, 1'b0);
      n_checks += 4;
      if (state !== seq[i][3:0]) begin n_fail++; $display("FAIL load state[%0d]: got %0d want %0d", i, state, seq[i]); end
      if (dut_ctrl !== exp_ctrl) begin n_fail++; $display("FAIL load ctrl[%0d]: got %b want %b", i, dut_ctrl, exp_ctrl); end
      if (illegal_op !== exp_illegal) begin n_fail++; $display("FAIL load illegal_op: got %b want %b", illegal_op, exp_illegal); end
      if (mem_err !== exp_memerr) begin n_fail++; $display("FAIL load mem_err: got %b want %b", mem_err, exp_memerr); end
      advance();
    end
  endtask

  task automatic test_store();
    int seq[5] = '{0, 1, 2, 5, 0};
    for (int i = 0; i < 5; i++) begin
      drive((i < 4) ? 1'b1 : 1'b0, 6'b101011, 1'b0);
      n_checks += 3;
      if (state !== seq[i][3:0]) begin n_fail++; $display("FAIL store state[%0d]: got %0d want %0d", i, state, seq[i]); end
      if (dut_ctrl !== exp_ctrl) begin n_fail++; $display("FAIL store ctrl[%0d]: got %b want %b", i, dut_ctrl, exp_ctrl); end
      if (i == 3 && (MemWrite !== 1'b1 || instr_done !== 1'b1)) begin
        n_fail++; $display("FAIL store strobe: got MemWrite=%b instr_done=%b want 1/1", MemWrite, instr_done);
      end
      advance();
    end
  endtask

  task automatic test_branch_jump();
    logic [5:0] ops[2] = '{6'b000100, 6'b000010};
    int         mid[2] = '{8, 9};
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 4; i++) begin
        drive((i < 3) ? 1'b1 : 1'b0, ops[k], 1'b0);
        n_checks += 2;
        if (i == 2 && state !== mid[k][3:0]) begin n_fail++; $display("FAIL brjmp state: got %0d want %0d", state, mid[k]); end
        else if (state !== exp_state) begin n_fail++; $display("FAIL brjmp state: got %0d want %0d", state, exp_state); end
        if (dut_ctrl !== exp_ctrl) begin n_fail++; $display("FAIL brjmp ctrl: got %b want %b", dut_ctrl, exp_ctrl); end
        advance();
      end
    end
  endtask

  task automatic test_timeout();
    logic [11:0] mr = 12'b000000000111;
    for (int i = 0; i < 12; i++) begin
      drive(mr[i], 6'b100011, 1'b0);
      n_checks += 3;
      if (state !== exp_state) begin n_fail++; $display("FAIL timeout state[%0d]: got %0d want %0d", i, state, exp_state); end
      if (dut_ctrl !== exp_ctrl) begin n_fail++; $display("FAIL timeout ctrl[%0d]: got %b want %b", i, dut_ctrl, exp_ctrl); end
      if (mem_err !== exp_memerr) begin n_fail++; $display("FAIL timeout mem_err[%0d]: got %b want %b", i, mem_err, exp_memerr); end
      if (i == 7 || i == 11) begin
        n_checks++;
        if (state !== 4'd0 || mem_err !== 1'b1) begin
          n_fail++; $display("FAIL timeout abort[%0d]: got state=%0d mem_err=%b want 0/1", i, state, mem_err);
        end
      end
      advance();
    end
  endtask

  task automatic test_illegal();
    logic [5:0] ops[2] = '{6'b111111, 6'b001000};
    for (int k = 0; k < 2; k++) begin
      int n    = (k == 1 && ADDI_EN) ? 5 : 4;
      int ills = 0;
      for (int i = 0; i < n; i++) begin
        drive((i < n - 2) ? 1'b1 : (i == n - 2 && n == 5), ops[k], 1'b0);
        n_checks += 3;
        if (state !== exp_state) begin n_fail++; $display("FAIL illegal state[%0d]: got %0d want %0d", i, state, exp_state); end
        if (dut_ctrl !== exp_ctrl) begin n_fail++; $display("FAIL illegal ctrl[%0d]: got %b want %b", i, dut_ctrl, exp_ctrl); end
        if (illegal_op !== exp_illegal) begin n_fail++; $display("FAIL illegal flag[%0d]: got %b want %b", i, illegal_op, exp_illegal); end
        if (illegal_op === 1'b1) ills++;
        advance();
      end
      n_checks++;
      if (ills != ((k == 1 && ADDI_EN) ? 0 : 1)) begin
        n_fail++; $display("FAIL illegal pulses op=%b: got %0d want %0d", ops[k], ills, (k == 1 && ADDI_EN) ? 0 : 1);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [5:0] ops[2] = '{6'b101011, 6'b000000};
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 5; i++) begin
        drive((i < 3) ? 1'b1 : 1'b0, ops[k], (i == 3));
        n_checks += 2;
        if (state !== exp_state) begin n_fail++; $display("FAIL rstmid state[%0d]: got %0d want %0d", i, state, exp_state); end
        if (dut_ctrl !== exp_ctrl) begin n_fail++; $display("FAIL rstmid ctrl[%0d]: got %b want %b", i, dut_ctrl, exp_ctrl); end
        if (i == 3) begin
          n_checks++;
          if (MemWrite !== 1'b0 || RegWrite !== 1'b0) begin
            n_fail++; $display("FAIL rstmid strobes: got MemWrite=%b RegWrite=%b want 0/0", MemWrite, RegWrite);
          end
        end
        advance();
      end
    end
  endtask

  task automatic test_random();
    logic [5:0] pool[7] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100,
                            6'b000010, 6'b001000, 6'b111111};
    logic [5:0] op    = 6'd0;
    int         burst = 0;
    for (int c = 0; c < 1500; c++) begin
      logic mr, rst;
      int   r;
      if (exp_state == 4'd0) begin
        r  = $urandom_range(0, 7);
        op = (r < 7) ? pool[r] : 6'($urandom);
      end
      if (burst > 0) begin
        mr = 1'b0; burst--;
      end else begin
        r  = $urandom_range(0, 15);
        if (r == 0) burst = $urandom_range(2, 6);
        mr = (r > 3);
      end
      rst = ($urandom_range(0, 199) == 0);
      drive(mr, op, rst);
      n_checks += 4;
      if (state !== exp_state) begin n_fail++; $display("FAIL random state c%0d: got %0d want %0d", c, state, exp_state); end
      if (dut_ctrl !== exp_ctrl) begin n_fail++; $display("FAIL random ctrl c%0d: got %b want %b", c, dut_ctrl, exp_ctrl); end
      if (illegal_op !== exp_illegal) begin n_fail++; $display("FAIL random illegal_op c%0d: got %b want %b", c, illegal_op, exp_illegal); end
      if (mem_err !== exp_memerr) begin n_fail++; $display("FAIL random mem_err c%0d: got %b want %b", c, mem_err, exp_memerr); end
      advance();
    end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_load();
    test_store();
    test_branch_jump();
    test_timeout();
    test_illegal();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/multi_cycle_controller.md
MULTI_CYCLE_CONTROLLER -- requirements
Module: multi_cycle_controller

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 15, giving the maximum consecutive cycles spent waiting for mem_ready before abort.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates occur on its rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous and active-high reset.
REQ-004 SHALL have port opcode, input, 6, instruction bits [31:26] from the instruction register.
REQ-005 SHALL have port mem_ready, input, 1, high when memory completes the current access this cycle.
REQ-006 SHALL have outputs PCWrite, Branch, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA, each 1 bit, with their usual datapath meanings.
REQ-007 SHALL have outputs ALUSrcB (2 bits: 00 reg B, 01 const 4, 10 sign-ext imm, 11 shifted imm), ALUop (2 bits: 00 add, 01 sub, 10 funct) and PCSource (2 bits: 00 ALU, 01 ALUOut, 10 jump target).
REQ-008 SHALL have outputs state (4 bits, current state code), instr_done (1 bit), illegal_op (1 bit) and mem_err (1 bit).

Function
REQ-009 SHALL implement states FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, JUMP=9, ADDIEX=10, ADDIWB=11; codes 12-15 SHALL go to FETCH on the next cycle.
REQ-010 Outputs not listed for a state SHALL be 0.
REQ-011 FETCH: MemRead=1, ALUSrcB=01. IRWrite and PCWrite SHALL be 1 only while mem_ready=1. Next state is DECODE when mem_ready=1, otherwise FETCH.
REQ-012 DECODE: ALUSrcB=11. Next state is MEMADR for 100011/101011, EXEC for 000000, BRANCH for 000100, JUMP for 000010, ADDIEX for 001000 (see REQ-024), and FETCH otherwise.
REQ-013 MEMADR: ALUSrcA=1, ALUSrcB=10. Next state is MEMRD if opcode=100011, otherwise MEMWR.
REQ-014 MEMRD: IorD=1, MemRead=1. Next state is MEMWB on mem_ready, otherwise MEMRD.
REQ-015 MEMWB: MemtoReg=1, RegWrite=1. MEMWR: IorD=1, MemWrite=1; exits to FETCH on mem_ready.
REQ-016 EXEC: ALUSrcA=1, ALUop=10, next ALUWB. ALUWB: RegDst=1, RegWrite=1, next FETCH.
REQ-017 BRANCH: ALUSrcA=1, ALUop=01, PCSource=01, Branch=1, next FETCH. JUMP: PCSource=10, PCWrite=1, next FETCH.
REQ-018 MEMWB, ALUWB, BRANCH, JUMP and ADDIWB SHALL go to FETCH unconditionally.
REQ-019 instr_done SHALL be high for exactly one cycle in MEMWB, ALUWB, BRANCH, JUMP and ADDIWB, and in MEMWR during the mem_ready cycle.
REQ-020 A wait counter SHALL count consecutive cycles spent in FETCH, MEMRD or MEMWR with mem_ready=0, and SHALL clear on mem_ready=1 or on a state change.
REQ-021 When the wait counter reaches MEM_TIMEOUT, the next state SHALL be FETCH, the counter SHALL clear, and mem_err SHALL be registered high for one cycle.
REQ-022 On an unsupported opcode in DECODE, illegal_op SHALL be registered high for exactly the following FETCH cycle, and no write strobe SHALL assert.

Reset
REQ-023 While reset=1 at a clock edge, the block SHALL set state=FETCH and clear the wait counter, instr_done, illegal_op and mem_err; reset mid-instruction SHALL abandon the instruction with no further RegWrite or MemWrite.

Configuration
REQ-024 Macro ADDI_SUPPORT_EN SHALL select addi support.
- Defined: opcode 001000 goes DECODE->ADDIEX (ALUSrcA=1, ALUSrcB=10) ->ADDIWB (RegWrite=1, RegDst=0, MemtoReg=0) ->FETCH.
- Undefined: 001000 is illegal (REQ-022), and states 10 and 11 behave as codes 12-15.

Verification
REQ-025 reset=1 for 2 cycles, then mem_ready=1, opcode=000000 -> states 0,1,6,7,0; ALUWB has RegWrite=1, RegDst=1; instr_done pulses once.
REQ-026 opcode=100011, mem_ready low for 3 cycles in MEMRD -> states 0,1,2,3,3,3,3,4,0; MemtoReg=1 in state 4.
REQ-027 opcode=101011, mem_ready=1 -> states 0,1,2,5,0; MemWrite=1 in state 5; instr_done high in state 5.
REQ-028 opcode=000100 then 000010 -> BRANCH with Branch=1, ALUop=01, PCSource=01; JUMP with PCWrite=1, PCSource=10.
REQ-029 MEM_TIMEOUT=4, mem_ready held 0 in MEMRD -> after 4 wait cycles state=0 with mem_err high for 1 cycle.
REQ-030 opcode=111111 -> DECODE->FETCH with illegal_op=1 for 1 cycle; opcode=001000 with and without ADDI_SUPPORT_EN -> states 10,11,0 versus an illegal_op pulse.
